accum_batch_processor: RTL and testbench
========================================

Name: accum_batch_processor

Overview:
- Parametrised successor to the two-operand bus accumulator processor.
- Fetches NUM_OPERANDS operands of DATA_W bits over the shared req/grant memory bus and reduces them with a selectable operation (sum or max).
- Returns the single result to memory over the same bus, then loops forever.
- Sits alongside the other processors on the arbitrated bus, with the same op/signal/read/write handshake.

Parameters:
- DATA_W, 32, width of the read/write data bus and of the accumulator.
- NUM_OPERANDS, 4, operands fetched per batch; legal range 2..256.
- CNT_W, 8, operand counter width; must satisfy 2**CNT_W >= NUM_OPERANDS.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- grant  input  1  bus grant from the arbiter.
- signal  input  1  memory acknowledge: data valid (FETCH) or data taken (SEND).
- read  input  DATA_W  operand from memory.
- mode  input  1  0 = sum, 1 = unsigned max; latched once per batch.
- op  output  2  bus opcode: 2'b01 FETCH, 2'b10 SEND, high-Z otherwise (2'b00 NOP is never driven).
- write  output  DATA_W  result; driven only in state SEND, high-Z otherwise.
- req  output  1  registered bus request.
- state  output  5  one-hot state, for debug and the bench.
- batch_done  output  1  one-cycle registered pulse when a result is accepted.

Behaviour:
- Reset values (asynchronous): state=REQF; req=0; batch_done=0; acc=0; k=0; mode_q=0; op=Z; write=Z.
- Reset mid-transaction aborts immediately. Any partial accumulation is discarded and the bus is released the same instant, because op, write and req depend only on state and registers.
- States, one-hot in this order: REQF=5'b00001, RECV=5'b00010, REQS=5'b00100, SEND=5'b01000, HOLD=5'b10000.
- REQF:
  - req<=1.
  - If grant && req: go to RECV.
  - Grant is ignored while req is still 0, so the first grant is honoured no earlier than the second cycle in REQF.
- RECV:
  - op=FETCH, driven combinationally from state.
  - On a cycle with signal=1: capture read; req<=0.
  - If k==0: acc<=read and mode_q<=mode.
  - Else: acc<=f(acc, read). In sum mode f is the sum modulo 2**DATA_W. In max mode f is the unsigned maximum.
  - k<=k+1.
  - If k==NUM_OPERANDS-1: go to REQS. Otherwise go to REQF.
  - With signal=0: hold state; acc is unchanged.
- REQS: req<=1; if grant && req: go to SEND.
- SEND:
  - op=SEND; write=acc.
  - On signal=1: req<=0; batch_done<=1; k<=0; go to HOLD.
- HOLD:
  - One dead cycle: bus released, op and write high-Z, batch_done back to 0.
  - Go to REQF.
  - Guarantees req is low for at least one cycle between batches.
- Latency with grant and signal returned one cycle after the request: 3 cycles per operand, plus 3 for the send, plus 1 for HOLD.
- mode is sampled only with the first operand. Changing mode mid-batch has no effect until the next batch.
- signal outside RECV/SEND is ignored. grant outside REQF/REQS is ignored.
- grant dropping while in RECV/SEND is ignored; the block completes on signal.
- Sum wrap example: 32'hFFFF_FFFF + 32'h2 gives 32'h1.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: in sum mode, an add that would overflow DATA_W clamps acc to all-ones. A sticky internal flag sets, and the result is sent as all-ones; the flag clears at k==0.
- Not defined: sum wraps modulo 2**DATA_W. Max mode is identical either way.

Decomposition:
- Package accum_pkg:
  - op codes OP_NOP/OP_FETCH/OP_SEND.
  - one-hot state constants.
  - mode constants MODE_SUM/MODE_MAX.
- Sub-module accum_alu: combinational f(acc, operand, mode, first), with the saturate logic under ACCUM_SATURATE_EN.
- The top level holds the FSM, counter, registers and tri-state drivers.

Test Plan:
- Sum, DATA_W=32, N=4: operands 1,2,3,4, mode=0, grant/signal one cycle after each request -> write=32'hA in SEND; one batch_done pulse; state returns to REQF.
- Max: operands 5, 32'h8000_0000, 7, 3 with mode=1 -> write=32'h8000_0000.
- Wrap (macro off): 32'hFFFF_FFFF, 1, 0, 0 -> write=0. Saturate (macro on): same operands -> write=32'hFFFF_FFFF.
- Handshake stalls: grant delayed 5 cycles and signal delayed 3 cycles per access -> op stays FETCH and req stays high throughout the stall; result unchanged (sum 10); op and write are Z whenever not in RECV/SEND.
- Reset asserted during the third operand's RECV -> op, write and req drop asynchronously. After release: k=0, acc=0; the next batch with operands 1,1,1,1 sends 4.
- mode toggled from 0 to 1 after the first operand -> the batch still sums; the next batch uses max.

Source files
------------

// File: rtl/accum_pkg.sv
// ============================================================================
// Module : accum_pkg
// Brief  : Shared opcodes, mode codes and one-hot states for accum_batch_processor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package accum_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef enum logic [4:0] {
    S_REQF = 5'b00001,
    S_RECV = 5'b00010,
    S_REQS = 5'b00100,
    S_SEND = 5'b01000,
    S_HOLD = 5'b10000
  } state_e;

endpackage

`default_nettype wire

// File: rtl/accum_alu.sv
// ============================================================================
// Module : accum_alu
// Brief  : Combinational reduction step f(acc, operand); ACCUM_SATURATE_EN
//          makes sum mode clamp to all-ones on overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module accum_alu
  import accum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic              mode_i,
  input  logic              first_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o
);

`ifdef ACCUM_SATURATE_EN
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, acc_i} + {1'b0, operand_i};
`endif

  always_comb begin
    result_o = operand_i;
    ovf_o    = 1'b0;
    if (!first_i) begin
      if (mode_i == MODE_SUM) begin
`ifdef ACCUM_SATURATE_EN
        ovf_o    = w_sum[DATA_W];
        result_o = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
        result_o = acc_i + operand_i;
`endif
      end else begin
        result_o = (operand_i > acc_i) ? operand_i : acc_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/accum_batch_processor.sv
// ============================================================================
// Module : accum_batch_processor
// Brief  : Fetches NUM_OPERANDS operands over the req/grant bus, reduces them
//          (sum or unsigned max) and sends the result back. Optional macro:
//          ACCUM_SATURATE_EN (saturating sum).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module accum_batch_processor
  import accum_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_OPERANDS = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant,
  input  logic              signal,
  input  logic [DATA_W-1:0] read,
  input  logic              mode,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] write,
  output logic              req,
  output logic [4:0]        state,
  output logic              batch_done
);

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_OPERANDS - 1);

  state_e            state_q;
  logic              req_q;
  logic              batch_done_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [CNT_W-1:0]  k_q;
  logic              mode_q;
  logic              sat_q;
  logic              w_first;
  logic              w_ovf;

  assign w_first = (k_q == '0);

  accum_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .acc_i     (acc_q),
    .operand_i (read),
    .mode_i    (mode_q),
    .first_i   (w_first),
    .result_o  (acc_d),
    .ovf_o     (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQF;
      req_q        <= 1'b0;
      batch_done_q <= 1'b0;
      acc_q        <= '0;
      k_q          <= '0;
      mode_q       <= MODE_SUM;
      sat_q        <= 1'b0;
    end else begin
      batch_done_q <= 1'b0;
      unique case (state_q)
        S_REQF: begin
          req_q <= 1'b1;
          // Registered req gates grant: no grant honoured in the first REQF cycle.
          if (grant && req_q) state_q <= S_RECV;
        end
        S_RECV: begin
          if (signal) begin
            req_q <= 1'b0;
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
            sat_q <= w_ovf | (sat_q & ~w_first);
            if (w_first) mode_q <= mode;
            state_q <= (k_q == LAST_K) ? S_REQS : S_REQF;
          end
        end
        S_REQS: begin
          req_q <= 1'b1;
          if (grant && req_q) state_q <= S_SEND;
        end
        S_SEND: begin
          if (signal) begin
            req_q        <= 1'b0;
            batch_done_q <= 1'b1;
            k_q          <= '0;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD:  state_q <= S_REQF;
        default: begin
          state_q <= S_REQF;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus outputs depend only on registers so an async reset releases them at once.
  assign op         = (state_q == S_RECV) ? OP_FETCH :
                      (state_q == S_SEND) ? OP_SEND  : 2'bzz;
  assign write      = (state_q == S_SEND) ? (sat_q ? {DATA_W{1'b1}} : acc_q)
                                          : {DATA_W{1'bz}};
  assign req        = req_q;
  assign state      = state_q;
  assign batch_done = batch_done_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_batch_processor.sv
// ============================================================================
// Module : tb_accum_batch_processor
// Brief  : Self-checking bench for accum_batch_processor (DATA_W=32, N=4);
//          expectations follow ACCUM_SATURATE_EN when it is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_accum_batch_processor;
  import accum_pkg::*;

  localparam logic [1:0]  OP_REL  = 2'b11;         // released bus seen through pull-ups
  localparam logic [31:0] W_REL   = 32'hFFFF_FFFF;
`ifdef ACCUM_SATURATE_EN
  localparam logic [31:0] EXP_OV1 = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_OV2 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_OV1 = 32'h0;
  localparam logic [31:0] EXP_OV2 = 32'h1;
`endif

  typedef struct {
    logic [3:0][31:0] ops;
    logic             mode0;
    logic             mode1;
    int               gd;
    int               sd;
    logic [31:0]      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, grant, signal, mode;
  logic [31:0] read;
  wire  [1:0]  op;
  wire  [31:0] write;
  wire         req, batch_done;
  wire  [4:0]  state;

  pullup (op);
  pullup (write);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  logic [31:0] exp_q[$];
  vec_t vecs[8];

  accum_batch_processor #(
    .DATA_W (32), .NUM_OPERANDS (4), .CNT_W (8)
  ) dut (
    .clk (clk), .reset (reset), .grant (grant), .signal (signal),
    .read (read), .mode (mode), .op (op), .write (write), .req (req),
    .state (state), .batch_done (batch_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset && state != S_RECV && state != S_SEND) begin
      check("idle_op_z", op, OP_REL);
      check("idle_write_z", write, W_REL);
    end
  end

  task automatic wait_for(input logic [4:0] s, input string tag);
    int n = 0;
    while (!(state == s && req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {state, req}, {s, 1'b1});
  endtask

  task automatic serve_fetch(input logic [31:0] val, input int gd, input int sd);
    wait_for(S_REQF, "fetch_req");
    repeat (gd) begin
      signal = 1'b1;                // stray acknowledge outside RECV must be ignored
      read   = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_req", req, 1'b1);
      check("stall_state", state, S_REQF);
    end
    signal = 1'b0;
    grant  = 1'b1;
    wait_for(S_RECV, "fetch_recv");
    grant = 1'b0;
    check("fetch_op", op, OP_FETCH);
    repeat (sd) begin
      @(negedge clk);
      check("recv_stall_op", op, OP_FETCH);
      check("recv_stall_req", req, 1'b1);
    end
    read   = val;
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
    read   = $urandom;
    check("fetch_req_drop", req, 1'b0);
  endtask

  task automatic serve_send(input int gd, input int sd, input string name);
    logic [31:0] e;
    wait_for(S_REQS, "send_req");
    repeat (gd) begin
      @(negedge clk);
      check("send_stall_state", state, S_REQS);
    end
    grant = 1'b1;
    wait_for(S_SEND, "send_state");
    grant = 1'b0;
    check("send_op", op, OP_SEND);
    repeat (sd) @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
      e = 32'h0;
    end else begin
      e = exp_q.pop_front();
    end
    check({name, "_write"}, write, e);
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
    check({name, "_hold"}, state, S_HOLD);
    check({name, "_done"}, batch_done, 1'b1);
    check({name, "_hold_req"}, req, 1'b0);
    @(negedge clk);
    check({name, "_back_reqf"}, state, S_REQF);
    check({name, "_done_pulse"}, batch_done, 1'b0);
    check({name, "_req_gap"}, req, 1'b0);
  endtask

  task automatic run_batch(input vec_t v, input string name);
    int c0;
    exp_q.push_back(v.exp);
    mode = v.mode0;
    c0   = cyc;
    for (int i = 0; i < 4; i++) begin
      serve_fetch(v.ops[i], v.gd, v.sd);
      if (i == 0) mode = v.mode1;
    end
    serve_send(v.gd, v.sd, name);
    if (v.gd == 0 && v.sd == 0) check({name, "_latency"}, cyc - c0, 16);
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, c, d, input logic m0, m1,
                              input int gd, sd, input logic [31:0] e);
    vec_t v;
    v.ops = {d, c, b, a};
    v.mode0 = m0; v.mode1 = m1; v.gd = gd; v.sd = sd; v.exp = e;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, 0, 0, 32'hA);
    vecs[1] = mk(32'd5, 32'h8000_0000, 32'd7, 32'd3, 1'b1, 1'b1, 0, 0, 32'h8000_0000);
    vecs[2] = mk(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, EXP_OV1);
    vecs[3] = mk(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, 5, 3, 32'd10);
    vecs[4] = mk(32'd2, 32'd9, 32'd4, 32'd1, 1'b0, 1'b1, 0, 0, 32'd16);
    vecs[5] = mk(32'd2, 32'd9, 32'd4, 32'd1, 1'b1, 1'b1, 0, 0, 32'd9);
    vecs[6] = mk(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, EXP_OV2);
    vecs[7] = mk(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 1'b1, 1'b1, 1, 1, 32'hFFFF_FFFF);

    reset = 1'b1; grant = 1'b0; signal = 1'b0; mode = 1'b0; read = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_state", state, S_REQF);
    check("rst_req", req, 1'b0);
    check("rst_done", batch_done, 1'b0);
    check("rst_op_z", op, OP_REL);
    check("rst_write_z", write, W_REL);
    reset  = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) run_batch(vecs[i], $sformatf("vec%0d", i));

    // Abort during the third operand's RECV.
    mode = 1'b0;
    serve_fetch(32'd7, 0, 0);
    serve_fetch(32'd8, 0, 0);
    wait_for(S_REQF, "abort_req");
    grant = 1'b1;
    wait_for(S_RECV, "abort_recv");
    grant = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_op_z", op, OP_REL);
    check("abort_write_z", write, W_REL);
    check("abort_req_low", req, 1'b0);
    check("abort_state", state, S_REQF);
    @(negedge clk);
    reset = 1'b0;
    run_batch(mk(32'd1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0, 0, 0, 32'd4), "after_rst");

    check("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
